// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM-AES input path.
// Block and IV types are MSB-first: index 0 is the first bit on the wire.
package gcm_pkg;

  localparam int GCM_BLK_W    = 128;
  localparam int GCM_BLK_LOG2 = 7;

  typedef logic [0:GCM_BLK_W-1] blk_t;
  typedef logic [0:95]          iv_t;
  typedef logic [0:63]          len_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AAD  = 2'd1,
    ST_PT   = 2'd2
  } feeder_state_e;

  // Number of 128-bit blocks covering a bit length; computed in 65 bits so the +127 cannot wrap.
  function automatic logic [57:0] blk_count(input logic [63:0] bits);
    logic [64:0] w_sum;
    w_sum = {1'b0, bits} + 65'd127;
    return w_sum[64:GCM_BLK_LOG2];
  endfunction

endpackage

// File: rtl/gcm_tail_mask.sv
// Zeroes the bits of a final partial block past the valid length; combinational, zero latency.
// A length remainder of 0 means the block is full and passes through untouched.
module gcm_tail_mask
  import gcm_pkg::*;
(
  input  blk_t                    i_blk,
  input  logic [GCM_BLK_LOG2-1:0] i_len,
  output blk_t                    o_blk
);

  blk_t w_keep;

  always_comb begin
    w_keep = '1;
    if (i_len != '0) begin
      w_keep = ~({GCM_BLK_W{1'b1}} >> i_len);
    end
  end

  assign o_blk = i_blk & w_keep;

endmodule

// File: rtl/gcm_aes_feeder.sv
// Sequences header + AAD/PT blocks into the pipeline, 1-cycle registered latency; input stalls become bubbles.
// Final partial blocks are masked only when GCM_FEEDER_PARTIAL_MASK_EN is defined.
module gcm_aes_feeder
  import gcm_pkg::*;
#(
  parameter int BLK_W = 128,
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hdr_valid,
  output logic             o_hdr_ready,
  input  logic [BLK_W-1:0] i_hdr_key,
  input  iv_t              i_hdr_iv,
  input  logic [LEN_W-1:0] i_hdr_aad_bits,
  input  logic [LEN_W-1:0] i_hdr_pt_bits,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  blk_t             i_data,
  output logic             o_blk_valid,
  output logic             o_new_instance,
  output logic             o_pt_instance,
  output logic [BLK_W-1:0] o_cipher_key,
  output iv_t              o_iv,
  output blk_t             o_aad,
  output blk_t             o_plain_text,
  output logic [LEN_W-1:0] o_aad_size,
  output logic [LEN_W-1:0] o_plain_text_size,
  output logic             o_busy
);

  feeder_state_e r_state;
  logic [57:0]   r_aad_left;
  logic [57:0]   r_pt_left;

  logic [57:0]   w_aad_n;
  logic [57:0]   w_pt_n;
  logic          w_hdr_acc;
  logic          w_data_acc;
  logic          w_last;
  blk_t          w_blk;

  assign w_aad_n = blk_count(i_hdr_aad_bits);
  assign w_pt_n  = blk_count(i_hdr_pt_bits);

  // Held low during reset so no header is taken while the datapath is clearing.
  assign o_hdr_ready  = ~rst & (r_state == ST_IDLE);
  assign o_data_ready = ((r_state == ST_AAD) && (r_aad_left != '0)) ||
                        ((r_state == ST_PT)  && (r_pt_left  != '0));

  assign w_hdr_acc  = i_hdr_valid  & o_hdr_ready;
  assign w_data_acc = i_data_valid & o_data_ready;
  assign w_last     = (r_state == ST_AAD) ? (r_aad_left == 58'd1) : (r_pt_left == 58'd1);

`ifdef GCM_FEEDER_PARTIAL_MASK_EN
  logic [GCM_BLK_LOG2-1:0] w_rem;

  assign w_rem = !w_last               ? '0 :
                 (r_state == ST_AAD)   ? o_aad_size[GCM_BLK_LOG2-1:0] :
                                         o_plain_text_size[GCM_BLK_LOG2-1:0];

  gcm_tail_mask u_tail_mask (
    .i_blk (i_data),
    .i_len (w_rem),
    .o_blk (w_blk)
  );
`else
  assign w_blk = i_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_aad_left        <= '0;
      r_pt_left         <= '0;
      o_blk_valid       <= 1'b0;
      o_new_instance    <= 1'b0;
      o_pt_instance     <= 1'b0;
      o_cipher_key      <= '0;
      o_iv              <= '0;
      o_aad             <= '0;
      o_plain_text      <= '0;
      o_aad_size        <= '0;
      o_plain_text_size <= '0;
      o_busy            <= 1'b0;
    end else begin
      o_blk_valid    <= w_hdr_acc | w_data_acc;
      o_new_instance <= w_hdr_acc;
      o_pt_instance  <= w_data_acc & (r_state == ST_PT);
      o_aad          <= (w_data_acc && (r_state == ST_AAD)) ? w_blk : '0;
      o_plain_text   <= (w_data_acc && (r_state == ST_PT))  ? w_blk : '0;
      // Any non-idle state still owes an output block next cycle, including the final one.
      o_busy         <= (r_state != ST_IDLE) | w_hdr_acc;

      case (r_state)
        ST_IDLE: begin
          if (w_hdr_acc) begin
            o_cipher_key      <= i_hdr_key;
            o_iv              <= i_hdr_iv;
            o_aad_size        <= i_hdr_aad_bits;
            o_plain_text_size <= i_hdr_pt_bits;
            r_aad_left        <= w_aad_n;
            r_pt_left         <= w_pt_n;
            r_state           <= (w_aad_n != '0) ? ST_AAD :
                                 ((w_pt_n != '0) ? ST_PT : ST_IDLE);
          end
        end
        ST_AAD: begin
          if (w_data_acc) begin
            r_aad_left <= r_aad_left - 58'd1;
            if (w_last) begin
              r_state <= (r_pt_left != '0) ? ST_PT : ST_IDLE;
            end
          end
        end
        ST_PT: begin
          if (w_data_acc) begin
            r_pt_left <= r_pt_left - 58'd1;
            if (w_last) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_aes_feeder.sv
// Bench for gcm_aes_feeder: directed and random messages checked cycle by cycle against a word-level model.
module tb_gcm_aes_feeder;
  import gcm_pkg::*;

`ifdef GCM_FEEDER_PARTIAL_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_hdr_valid;
  logic         o_hdr_ready;
  logic [127:0] i_hdr_key;
  iv_t          i_hdr_iv;
  logic [63:0]  i_hdr_aad_bits;
  logic [63:0]  i_hdr_pt_bits;
  logic         i_data_valid;
  logic         o_data_ready;
  blk_t         i_data;
  logic         o_blk_valid;
  logic         o_new_instance;
  logic         o_pt_instance;
  logic [127:0] o_cipher_key;
  iv_t          o_iv;
  blk_t         o_aad;
  blk_t         o_plain_text;
  logic [63:0]  o_aad_size;
  logic [63:0]  o_plain_text_size;
  logic         o_busy;

  always #5 clk = ~clk;

  gcm_aes_feeder #(.BLK_W(128), .LEN_W(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_hdr_valid       (i_hdr_valid),
    .o_hdr_ready       (o_hdr_ready),
    .i_hdr_key         (i_hdr_key),
    .i_hdr_iv          (i_hdr_iv),
    .i_hdr_aad_bits    (i_hdr_aad_bits),
    .i_hdr_pt_bits     (i_hdr_pt_bits),
    .i_data_valid      (i_data_valid),
    .o_data_ready      (o_data_ready),
    .i_data            (i_data),
    .o_blk_valid       (o_blk_valid),
    .o_new_instance    (o_new_instance),
    .o_pt_instance     (o_pt_instance),
    .o_cipher_key      (o_cipher_key),
    .o_iv              (o_iv),
    .o_aad             (o_aad),
    .o_plain_text      (o_plain_text),
    .o_aad_size        (o_aad_size),
    .o_plain_text_size (o_plain_text_size),
    .o_busy            (o_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: a message needs a fixed number of words; it is "active" while any remain.
  bit           m_active;
  int           m_aad_n, m_pt_n, m_idx;
  logic [63:0]  m_aad_bits, m_pt_bits;
  bit           last_hacc, last_dacc;

  logic         e_vld, e_new, e_pt, e_busy;
  blk_t         e_aad, e_ptd;
  logic [127:0] e_key;
  iv_t          e_iv;
  logic [63:0]  e_asz, e_psz;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nblk(input logic [63:0] bits);
    logic [64:0] s;
    s = {1'b0, bits} + 65'd127;
    return int'(s / 65'd128);
  endfunction

  function automatic blk_t mask_model(input blk_t d, input logic [63:0] bits, input bit last);
    blk_t r;
    int   keep;
    r    = d;
    keep = int'(bits % 64'd128);
    if (MASK_ON && last && keep != 0)
      for (int j = keep; j < 128; j++) r[j] = 1'b0;
    return r;
  endfunction

  function automatic blk_t new_word(input bit ones);
    blk_t w;
    w = ones ? '1 : {$urandom, $urandom, $urandom, $urandom};
    return w;
  endfunction

  function automatic bit pick(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      2:       return (t % 2 == 0);
      default: return ($urandom_range(0, 1) != 0);
    endcase
  endfunction

  task automatic model_clear();
    m_active = 1'b0; m_idx = 0; m_aad_n = 0; m_pt_n = 0;
    m_aad_bits = '0; m_pt_bits = '0;
    e_vld = 1'b0; e_new = 1'b0; e_pt = 1'b0; e_busy = 1'b0;
    e_aad = '0; e_ptd = '0; e_key = '0; e_iv = '0; e_asz = '0; e_psz = '0;
    last_hacc = 1'b0; last_dacc = 1'b0;
  endtask

  // Called mid-cycle: check this cycle's outputs, then predict the next from the sampled inputs.
  task automatic model_step();
    bit hacc, dacc;
    chk("blk_valid",  256'(o_blk_valid),       256'(e_vld));
    chk("new_inst",   256'(o_new_instance),    256'(e_new));
    chk("pt_inst",    256'(o_pt_instance),     256'(e_pt));
    chk("aad",        256'(o_aad),             256'(e_aad));
    chk("plain_text", 256'(o_plain_text),      256'(e_ptd));
    chk("key",        256'(o_cipher_key),      256'(e_key));
    chk("iv",         256'(o_iv),              256'(e_iv));
    chk("aad_size",   256'(o_aad_size),        256'(e_asz));
    chk("pt_size",    256'(o_plain_text_size), 256'(e_psz));
    chk("busy",       256'(o_busy),            256'(e_busy));
    chk("hdr_ready",  256'(o_hdr_ready),       256'(!rst && !m_active));
    chk("data_ready", 256'(o_data_ready),      256'(!rst && m_active));
    last_hacc = 1'b0; last_dacc = 1'b0;
    e_vld = 1'b0; e_new = 1'b0; e_pt = 1'b0; e_aad = '0; e_ptd = '0;
    if (rst) begin
      model_clear();
      return;
    end
    hacc = i_hdr_valid && !m_active;
    dacc = i_data_valid && m_active;
    if (hacc) begin
      e_key = i_hdr_key; e_iv = i_hdr_iv; e_asz = i_hdr_aad_bits; e_psz = i_hdr_pt_bits;
      m_aad_bits = i_hdr_aad_bits; m_pt_bits = i_hdr_pt_bits;
      m_aad_n = nblk(i_hdr_aad_bits); m_pt_n = nblk(i_hdr_pt_bits); m_idx = 0;
      m_active = (m_aad_n + m_pt_n) > 0;
      e_vld = 1'b1; e_new = 1'b1;
    end
    if (dacc) begin
      if (m_idx < m_aad_n) begin
        e_aad = mask_model(i_data, m_aad_bits, m_idx == m_aad_n - 1);
      end else begin
        e_pt  = 1'b1;
        e_ptd = mask_model(i_data, m_pt_bits, m_idx == m_aad_n + m_pt_n - 1);
      end
      e_vld = 1'b1;
      m_idx++;
      if (m_idx == m_aad_n + m_pt_n) m_active = 1'b0;
    end
    e_busy = hacc || dacc || m_active;
    last_hacc = hacc; last_dacc = dacc;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input logic [63:0] ab, input logic [63:0] pb, input int mode,
                          input bit ones, input int abort_after);
    int need, taken, t, budget;
    bit hdone;
    need = nblk(ab) + nblk(pb); taken = 0; t = 0; budget = 2000; hdone = 1'b0;
    i_hdr_key      = {$urandom, $urandom, $urandom, $urandom};
    i_hdr_iv       = {$urandom, $urandom, $urandom};
    i_hdr_aad_bits = ab;
    i_hdr_pt_bits  = pb;
    i_hdr_valid    = 1'b1;
    i_data         = new_word(ones);
    i_data_valid   = pick(mode, t);
    while ((!hdone || taken < need) && budget > 0) begin
      cyc();
      budget--; t++;
      if (last_hacc) begin
        hdone = 1'b1;
        i_hdr_valid = 1'b0;
        i_hdr_key = {$urandom, $urandom, $urandom, $urandom};
        i_hdr_iv  = {$urandom, $urandom, $urandom};
        i_hdr_aad_bits = 64'($urandom); i_hdr_pt_bits = 64'($urandom);
      end
      if (last_dacc) begin
        taken++;
        i_data = new_word(ones);
      end
      if (abort_after > 0 && taken == abort_after) break;
      i_data_valid = pick(mode, t);
    end
    n_cmp++;
    assert (budget > 0) else begin
      n_err++;
      $error("FAIL msg_timeout: observed %0d words taken, expected %0d", taken, need);
    end
    i_data_valid = 1'b0;
    i_hdr_valid  = 1'b0;
  endtask

  initial begin
    i_hdr_valid = 1'b0; i_hdr_key = '0; i_hdr_iv = '0; i_hdr_aad_bits = '0;
    i_hdr_pt_bits = '0; i_data_valid = 1'b0; i_data = '0;
    model_clear();
    repeat (3) cyc();
    rst = 1'b0;
    repeat (2) cyc();

    // One AAD block then two PT blocks, data held valid.
    send_msg(64'd128, 64'd256, 0, 1'b0, 0);
    repeat (3) cyc();
    // Zero-length message: only the new-instance cycle.
    send_msg(64'd0, 64'd0, 0, 1'b0, 0);
    repeat (2) cyc();
    // Partial final blocks on both phases with all-ones data.
    send_msg(64'd200, 64'd8, 0, 1'b1, 0);
    repeat (2) cyc();
    // Alternating data valid during PT gives block / bubble / block.
    send_msg(64'd0, 64'd384, 2, 1'b0, 0);
    repeat (2) cyc();

    // Reset while the first of three PT blocks is on the outputs.
    send_msg(64'd0, 64'd384, 0, 1'b0, 1);
    @(negedge clk);
    model_step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_blk_valid", 256'(o_blk_valid),  256'(0));
    chk("rst_busy",      256'(o_busy),       256'(0));
    chk("rst_key",       256'(o_cipher_key), 256'(0));
    chk("rst_pt_size",   256'(o_plain_text_size), 256'(0));
    chk("rst_hdr_ready", 256'(o_hdr_ready),  256'(0));
    model_clear();
    @(posedge clk);
    #1;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    send_msg(64'd128, 64'd128, 0, 1'b0, 0);

    // Back-to-back messages with no idle gap.
    send_msg(64'd256, 64'd128, 0, 1'b0, 0);
    send_msg(64'd0, 64'd256, 0, 1'b0, 0);
    repeat (3) cyc();

    for (int k = 0; k < 25; k++) begin
      send_msg(64'($urandom_range(0, 700)), 64'($urandom_range(0, 700)),
               int'($urandom_range(0, 3)), 1'b0, 0);
      repeat ($urandom_range(0, 3)) cyc();
    end
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
